// File: rtl/mfm_acq_sequencer_pkg.sv
// Shared encodings for the acquisition start/stop sequencer.
package mfm_acq_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_IMMEDIATE  = 2'b00,
        MODE_INDEX      = 2'b01,
        MODE_SYNC       = 2'b10,
        MODE_INDEX_SYNC = 2'b11
    } wait_mode_t;

    typedef enum logic [1:0] {
        STATUS_OK       = 2'b00,
        STATUS_TIMEOUT  = 2'b01,
        STATUS_ABORT    = 2'b10,
        STATUS_MEM_FULL = 2'b11
    } status_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_WAIT_INDEX = 2'b01,
        ST_WAIT_SYNC  = 2'b10,
        ST_ACQUIRE    = 2'b11
    } state_t;

endpackage

// File: rtl/mfm_acq_sequencer_sync.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
module async_edge_sync (
    input  logic CLK_PLL32MHZ,
    input  logic RESET_n,
    input  logic ASYNC_IN,
    output logic EDGE_PULSE
);

    logic meta;
    logic sync;
    logic sync_d;

    // Synchronize the async level, then pulse one cycle on its rising edge.
    always_ff @(posedge CLK_PLL32MHZ or negedge RESET_n) begin
        if (!RESET_n) begin
            meta       <= 1'b0;
            sync       <= 1'b0;
            sync_d     <= 1'b0;
            EDGE_PULSE <= 1'b0;
        end else begin
            meta       <= ASYNC_IN;
            sync       <= meta;
            sync_d     <= sync;
            EDGE_PULSE <= sync & ~sync_d;
        end
    end

endmodule

// File: rtl/mfm_acq_sequencer.sv
// Acquisition start/stop sequencer: arms on START, waits for the selected
// trigger, gates the acquisition-memory write enable and reports the outcome.
module mfm_acq_sequencer
    import mfm_acq_sequencer_pkg::*;
#(
    parameter int IDX_CNT_W  = 8,
    parameter int SYNC_CNT_W = 4,
    parameter int GAP_W      = 10
) (
    input  logic                  CLK_PLL32MHZ,
    input  logic                  RESET_n,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic [1:0]            WAIT_MODE,
    input  logic [SYNC_CNT_W-1:0] SYNC_COUNT,
    input  logic [GAP_W-1:0]      SYNC_GAP_MAX,
    input  logic [IDX_CNT_W-1:0]  TIMEOUT_IDX,
    input  logic [IDX_CNT_W-1:0]  STOP_IDX,
    input  logic                  SYNC_WORD_DETECTED,
    input  logic                  FD_INDEX_IN,
    input  logic                  MEM_FULL,
    output logic                  ACQ_WRITE_EN,
    output logic                  BUSY,
    output logic                  WAITING,
    output logic                  DONE,
    output logic [1:0]            STATUS
);

    logic idx_evt;
    logic sync_evt;

    state_t     state, state_nxt;
    wait_mode_t mode_q, mode_nxt;
    status_t    status_q, status_nxt;
    logic       done_nxt;

    logic [IDX_CNT_W-1:0]  wait_idx, wait_idx_nxt, wait_idx_inc;
    logic [IDX_CNT_W-1:0]  acq_idx, acq_idx_nxt, acq_idx_inc;
    logic [SYNC_CNT_W-1:0] sync_cnt, sync_cnt_nxt, sync_base, sync_inc, sync_target;
    logic [GAP_W-1:0]      gap_tmr, gap_nxt, gap_inc;
    logic                  gap_expired;

    // The index pin is active-low, so invert it to make the falling pin edge the event.
    async_edge_sync u_idx_sync (
        .CLK_PLL32MHZ (CLK_PLL32MHZ),
        .RESET_n      (RESET_n),
        .ASYNC_IN     (~FD_INDEX_IN),
        .EDGE_PULSE   (idx_evt)
    );

    async_edge_sync u_sw_sync (
        .CLK_PLL32MHZ (CLK_PLL32MHZ),
        .RESET_n      (RESET_n),
        .ASYNC_IN     (SYNC_WORD_DETECTED),
        .EDGE_PULSE   (sync_evt)
    );

    // Saturating increments, gap-limit test and effective sync target.
    always_comb begin
        wait_idx_inc = (wait_idx == '1) ? wait_idx : wait_idx + 1'b1;
        acq_idx_inc  = (acq_idx == '1) ? acq_idx : acq_idx + 1'b1;
        gap_inc      = (gap_tmr == '1) ? gap_tmr : gap_tmr + 1'b1;
        gap_expired  = (SYNC_GAP_MAX != '0) && (gap_tmr > SYNC_GAP_MAX);
        sync_base    = gap_expired ? '0 : sync_cnt;
        sync_inc     = (sync_base == '1) ? sync_base : sync_base + 1'b1;
        sync_target  = (SYNC_COUNT == '0) ? SYNC_CNT_W'(1) : SYNC_COUNT;
    end

    // Next-state, counter and status logic; abort beats memory-full beats stop/timeout beats triggers.
    always_comb begin
        state_nxt    = state;
        mode_nxt     = mode_q;
        status_nxt   = status_q;
        done_nxt     = 1'b0;
        wait_idx_nxt = wait_idx;
        acq_idx_nxt  = acq_idx;
        sync_cnt_nxt = sync_cnt;
        gap_nxt      = gap_tmr;

        case (state)
            ST_IDLE: begin
                if (START && !ABORT) begin
                    mode_nxt     = wait_mode_t'(WAIT_MODE);
                    status_nxt   = STATUS_OK;
                    wait_idx_nxt = '0;
                    acq_idx_nxt  = '0;
                    sync_cnt_nxt = '0;
                    gap_nxt      = '0;
                    case (wait_mode_t'(WAIT_MODE))
                        MODE_IMMEDIATE: state_nxt = ST_ACQUIRE;
                        MODE_SYNC:      state_nxt = ST_WAIT_SYNC;
                        default:        state_nxt = ST_WAIT_INDEX;
                    endcase
                end
            end

            ST_WAIT_INDEX: begin
                if (ABORT) begin
                    state_nxt  = ST_IDLE;
                    status_nxt = STATUS_ABORT;
                    done_nxt   = 1'b1;
                end else if (idx_evt) begin
                    // The index that satisfies this wait always wins over a timeout.
                    wait_idx_nxt = wait_idx_inc;
                    state_nxt    = (mode_q == MODE_INDEX) ? ST_ACQUIRE : ST_WAIT_SYNC;
                end
            end

            ST_WAIT_SYNC: begin
                if (ABORT) begin
                    state_nxt  = ST_IDLE;
                    status_nxt = STATUS_ABORT;
                    done_nxt   = 1'b1;
                end else begin
                    gap_nxt      = gap_inc;
                    sync_cnt_nxt = sync_base;
                    if (idx_evt) begin
                        wait_idx_nxt = wait_idx_inc;
                    end
                    if (idx_evt && (TIMEOUT_IDX != '0) && (wait_idx_inc >= TIMEOUT_IDX)) begin
                        state_nxt  = ST_IDLE;
                        status_nxt = STATUS_TIMEOUT;
                        done_nxt   = 1'b1;
                    end else if (sync_evt) begin
                        sync_cnt_nxt = sync_inc;
                        gap_nxt      = '0;
                        if (sync_inc == sync_target) begin
                            state_nxt = ST_ACQUIRE;
                        end
                    end
                end
            end

            ST_ACQUIRE: begin
                if (ABORT) begin
                    state_nxt  = ST_IDLE;
                    status_nxt = STATUS_ABORT;
                    done_nxt   = 1'b1;
                end else if (MEM_FULL) begin
                    state_nxt  = ST_IDLE;
                    status_nxt = STATUS_MEM_FULL;
                    done_nxt   = 1'b1;
                end else if (idx_evt) begin
                    acq_idx_nxt = acq_idx_inc;
                    if ((STOP_IDX != '0) && (acq_idx_inc >= STOP_IDX)) begin
                        state_nxt  = ST_IDLE;
                        status_nxt = STATUS_OK;
                        done_nxt   = 1'b1;
                    end
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs derived from the next state.
    always_ff @(posedge CLK_PLL32MHZ or negedge RESET_n) begin
        if (!RESET_n) begin
            state        <= ST_IDLE;
            mode_q       <= MODE_IMMEDIATE;
            status_q     <= STATUS_OK;
            wait_idx     <= '0;
            acq_idx      <= '0;
            sync_cnt     <= '0;
            gap_tmr      <= '0;
            ACQ_WRITE_EN <= 1'b0;
            BUSY         <= 1'b0;
            WAITING      <= 1'b0;
            DONE         <= 1'b0;
        end else begin
            state        <= state_nxt;
            mode_q       <= mode_nxt;
            status_q     <= status_nxt;
            wait_idx     <= wait_idx_nxt;
            acq_idx      <= acq_idx_nxt;
            sync_cnt     <= sync_cnt_nxt;
            gap_tmr      <= gap_nxt;
            ACQ_WRITE_EN <= (state_nxt == ST_ACQUIRE);
            BUSY         <= (state_nxt != ST_IDLE);
            WAITING      <= (state_nxt == ST_WAIT_INDEX) || (state_nxt == ST_WAIT_SYNC);
            DONE         <= done_nxt;
        end
    end

    assign STATUS = status_q;

endmodule

// File: doc/mfm_acq_sequencer.md
# mfm_acq_sequencer

Acquisition start/stop sequencer for the floppy read path. Arms on a host START strobe and waits for the configured trigger: immediate, index pulse, MFM sync-word match, or index followed by sync. It then holds the acquisition-memory write enable until a stop condition occurs, and reports completion, timeout or abort. It consumes the sync-word detector's match flag and the drive index line, both asynchronous to this block.

## Interface
Parameters:
- IDX_CNT_W, 8, width of index-pulse counters
- SYNC_CNT_W, 4, width of required-sync counter
- GAP_W, 10, width of sync-gap timer

Ports:
- CLK_PLL32MHZ  in  1  master clock
- RESET_n  in  1  asynchronous, active-low reset
- START  in  1  one-cycle arm strobe; ignored unless IDLE
- ABORT  in  1  level; forces return to IDLE
- WAIT_MODE  in  2  trigger: 00 immediate, 01 index, 10 sync, 11 index then sync
- SYNC_COUNT  in  SYNC_CNT_W  sync matches required; 0 treated as 1
- SYNC_GAP_MAX  in  GAP_W  max clocks between successive matches; 0 = no gap limit
- TIMEOUT_IDX  in  IDX_CNT_W  index pulses allowed while waiting; 0 = never time out
- STOP_IDX  in  IDX_CNT_W  index pulses ending acquisition; 0 = run until MEM_FULL/ABORT
- SYNC_WORD_DETECTED  in  1  async match level from the sync detector
- FD_INDEX_IN  in  1  async drive index, active-low
- MEM_FULL  in  1  acquisition memory full, synchronous
- ACQ_WRITE_EN  out  1  high in ACQUIRE
- BUSY  out  1  high in any non-IDLE state
- WAITING  out  1  high in WAIT_INDEX or WAIT_SYNC
- DONE  out  1  one-cycle pulse on any exit to IDLE
- STATUS  out  2  00 ok, 01 timeout, 10 abort, 11 mem full; held until the next accepted START

## Operation
- Input conditioning: SYNC_WORD_DETECTED and FD_INDEX_IN each pass through a two-flop synchronizer and a rising-edge detector. Index is inverted first, so the falling edge of the pin is the event.
- States: IDLE, WAIT_INDEX, WAIT_SYNC, ACQUIRE.
- IDLE + START: clear STATUS, the counters and the gap timer.
  - Mode 00 → ACQUIRE.
  - Mode 01 or 11 → WAIT_INDEX.
  - Mode 10 → WAIT_SYNC.
- WAIT_INDEX + index event:
  - Mode 01 → ACQUIRE.
  - Mode 11 → WAIT_SYNC.
  - A sync event in the same cycle is discarded.
- WAIT_SYNC + sync event:
  - Increment the match count and restart the gap timer.
  - When the count equals max(SYNC_COUNT,1) → ACQUIRE.
  - If the gap timer exceeds a nonzero SYNC_GAP_MAX, reset the match count to 0.
- Timeout: wait_idx counts index events in both WAIT states.
  - If TIMEOUT_IDX≠0 and wait_idx reaches TIMEOUT_IDX while still waiting → IDLE with STATUS=01.
  - A wait-satisfying index event takes precedence over a timeout in the same cycle.
- ACQUIRE: acq_idx counts index events. The index event that entered ACQUIRE is not counted.
  - If STOP_IDX≠0 and acq_idx reaches STOP_IDX → IDLE with STATUS=00.
  - MEM_FULL → IDLE with STATUS=11.
- Priority per cycle: ABORT (STATUS=10, from any non-IDLE state) > MEM_FULL > STOP/timeout > trigger events.
- ABORT in IDLE has no effect. START while BUSY is ignored. START and ABORT together in IDLE: ABORT wins and nothing is armed.
- Counters saturate at all-ones and never wrap. The gap timer saturates.

## Timing
- Reset values: ACQ_WRITE_EN=0, BUSY=0, WAITING=0, DONE=0, STATUS=00, state IDLE, all counters 0.
- All outputs are registered.
- START → BUSY=1 at the next edge. In mode 00, ACQ_WRITE_EN=1 at the same edge.
- Async input edge → internal event 3 clocks later: 2 sync flops + edge register. The state change is visible at the edge after the event.
- A stop condition drops ACQ_WRITE_EN and BUSY, and pulses DONE, at the same edge.
- Reset assertion mid-operation clears everything immediately. No DONE pulse is generated.

## Structure
- Shared package header holds:
  - WAIT_MODE encodings
  - STATUS encodings
  - state encodings
- Sub-module async_edge_sync (2-flop synchronizer + rising-edge pulse, async active-low reset) is instantiated twice, once per async input.
- FSM, counters and gap timer live in the top level.

## Test plan
- Mode 00, STOP_IDX=2: START, then index pulses at 1000 and 5000 clocks. ACQ_WRITE_EN rises 1 clock after START and falls 4 clocks after the second index. DONE pulses, STATUS=00.
- Mode 11, SYNC_COUNT=3, SYNC_GAP_MAX=600: index, then matches at +100, +600, +1100 clocks after index. ACQUIRE is entered after the third match. Repeat with a +800 gap before the third match; the count resets and no ACQUIRE occurs.
- Mode 10, TIMEOUT_IDX=2, no sync activity: two index pulses → STATUS=01, DONE, BUSY=0.
- Mode 01, TIMEOUT_IDX=1, one index pulse: enters ACQUIRE, not a timeout (precedence check).
- ACQUIRE with MEM_FULL and ABORT in the same cycle → STATUS=10. MEM_FULL alone → 11.
- START while BUSY is ignored. RESET_n pulsed mid-ACQUIRE → all outputs 0 immediately, no DONE pulse.
